led_pattern_checker: RTL and testbench

LED_PATTERN_CHECKER -- requirements
Module: led_pattern_checker

---
 rtl/led_pattern_pkg.sv | 17 +
 rtl/led_bar_decode.sv | 19 +
 rtl/led_pattern_checker.sv | 60 ++++++
 tb/tb_led_pattern_checker.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: shared widths, FSM state type and centre-expanding bar patterns.
package led_pattern_pkg;
    localparam int LED_W = 16;
    localparam int MAX_LEVEL = 8;
    localparam int LVL_W = 4;
    typedef enum logic {HUNT, LOCKED} state_t;
    localparam logic [LED_W-1:0] P0 = 16'h0000;
    localparam logic [LED_W-1:0] P1 = 16'h0180;
    localparam logic [LED_W-1:0] P2 = 16'h03C0;
    localparam logic [LED_W-1:0] P3 = 16'h07E0;
    localparam logic [LED_W-1:0] P4 = 16'h0FF0;
    localparam logic [LED_W-1:0] P5 = 16'h1FF8;
    localparam logic [LED_W-1:0] P6 = 16'h3FFC;
    localparam logic [LED_W-1:0] P7 = 16'h7FFE;
    localparam logic [LED_W-1:0] P8 = 16'hFFFF;
    localparam logic [LED_W-1:0] PAT [MAX_LEVEL+1] = '{P0, P1, P2, P3, P4, P5, P6, P7, P8};
endpackage

// File: rtl/led_bar_decode.sv
// led_bar_decode: combinational match of led against the legal bar patterns.
module led_bar_decode
    import led_pattern_pkg::*;
(
    input  logic [LED_W-1:0] led,
    output logic             legal,
    output logic [LVL_W-1:0] lvl
);
    always_comb begin
        legal = 1'b0;
        lvl = '0;
        for (int k = 0; k <= MAX_LEVEL; k++) begin
            if (led == PAT[k]) begin
                legal = 1'b1;
                lvl = LVL_W'(k);
            end
        end
    end
endmodule

// File: rtl/led_pattern_checker.sv
// led_pattern_checker: tracks a P0..P8 bar sweep, flags sequence errors and counts them.
module led_pattern_checker
    import led_pattern_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic [LED_W-1:0] led,
    output logic [LVL_W-1:0] level,
    output logic             valid,
    output logic             locked,
    output logic             seq_err,
    output logic             sweep_done,
    output logic [ERR_W-1:0] err_count
);
    logic             legal;
    logic [LVL_W-1:0] lvl;
    logic [LVL_W-1:0] exp_lvl;
    state_t           state;

    led_bar_decode u_dec (.led(led), .legal(legal), .lvl(lvl));

    assign locked = state == LOCKED;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
            exp_lvl <= '0;
            level <= '0;
            valid <= 1'b0;
            seq_err <= 1'b0;
            sweep_done <= 1'b0;
            err_count <= '0;
        end else begin
            seq_err <= 1'b0;
            sweep_done <= 1'b0;
            if (sample_en) begin
                level <= lvl;
                valid <= legal;
                if (state == HUNT) begin
                    if (legal && lvl == '0) begin
                        state <= LOCKED;
                        exp_lvl <= LVL_W'(1);
                    end
                end else if (legal && lvl == exp_lvl) begin
                    // level 8 completes a sweep; expectation wraps back to P0
                    sweep_done <= exp_lvl == LVL_W'(MAX_LEVEL);
                    exp_lvl <= (exp_lvl == LVL_W'(MAX_LEVEL)) ? '0 : exp_lvl + 1'b1;
                end else begin
                    seq_err <= 1'b1;
                    err_count <= (err_count == '1) ? err_count : err_count + 1'b1;
                    state <= HUNT;
                    exp_lvl <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_led_pattern_checker.sv
// tb_led_pattern_checker: directed + random stimulus, scoreboard against a behavioural model.
module tb_led_pattern_checker;
    localparam int ERR_W = 2;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sample_en = 1'b0;
    logic [15:0]      led = '0;
    logic [3:0]       level;
    logic             valid, locked, seq_err, sweep_done;
    logic [ERR_W-1:0] err_count;

    led_pattern_checker #(.ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .led(led),
        .level(level), .valid(valid), .locked(locked),
        .seq_err(seq_err), .sweep_done(sweep_done), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int level;
        int valid;
        int locked;
        int seq;
        int sweep;
        int errc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passed = 0;

    // behavioural model state
    bit m_lock = 0;
    int m_exp = 0;
    int m_level = 0;
    int m_valid = 0;
    int m_err = 0;

    function automatic logic [15:0] pat(input int k);
        if (k == 0) return 16'h0000;
        return 16'((((32'd1 << (2 * k)) - 1)) << (8 - k));
    endfunction

    function automatic void decode(input logic [15:0] l, output bit lg, output int lv);
        lg = 0;
        lv = 0;
        for (int k = 0; k <= 8; k++) if (l == pat(k)) begin lg = 1; lv = k; end
    endfunction

    function automatic void push(input int seq, input int sweep);
        exp_t e;
        e.level = m_level; e.valid = m_valid; e.locked = int'(m_lock);
        e.seq = seq; e.sweep = sweep; e.errc = m_err;
        q.push_back(e);
    endfunction

    function automatic void model_reset();
        m_lock = 0; m_exp = 0; m_level = 0; m_valid = 0; m_err = 0;
    endfunction

    function automatic void model(input bit en, input logic [15:0] l, input bit r);
        bit lg;
        int lv;
        int seq = 0;
        int sweep = 0;
        if (r) model_reset();
        else if (en) begin
            decode(l, lg, lv);
            m_level = lv;
            m_valid = int'(lg);
            if (!m_lock) begin
                if (lg && lv == 0) begin m_lock = 1; m_exp = 1; end
            end else if (lg && lv == m_exp) begin
                sweep = int'(m_exp == 8);
                m_exp = (m_exp + 1) % 9;
            end else begin
                seq = 1;
                m_err = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
                m_lock = 0;
            end
        end
        push(seq, sweep);
    endfunction

    task automatic step(input bit en, input logic [15:0] l, input bit r);
        @(negedge clk);
        rst = r;
        sample_en = en;
        led = l;
        model(en, l, r);
    endtask

    task automatic go(input int k);
        step(1, pat(k), 0);
    endtask

    // reset lands just after a rising edge, long before the next one
    task automatic async_rst();
        @(negedge clk);
        sample_en = 0;
        led = $urandom;
        model_reset();
        push(0, 0);
        @(posedge clk);
        #1 rst = 1;
    endtask

    task automatic chk(input string n, input int got, input int want);
        checks++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", n, got, want, $time);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("level", int'(level), e.level);
                chk("valid", int'(valid), e.valid);
                chk("locked", int'(locked), e.locked);
                chk("seq_err", int'(seq_err), e.seq);
                chk("sweep_done", int'(sweep_done), e.sweep);
                chk("err_count", int'(err_count), e.errc);
                chk("pulse_excl", int'(seq_err & sweep_done), 0);
            end
        end
    end

    initial begin : stim
        int r;
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 1);
        for (int k = 0; k <= 8; k++) go(k);
        go(0);
        go(0);
        go(0);
        go(1); go(2); go(4);
        go(0); go(1); go(2);
        step(1, 16'h0180, 0);
        go(0); go(1); go(2);
        step(1, 16'h0100, 0);
        go(0);
        go(1); go(2);
        for (int i = 0; i < 5; i++) step(0, 16'($urandom), 0);
        go(3);
        for (int k = 4; k <= 8; k++) go(k);
        go(0);
        step(1, 16'h1234, 0);
        step(1, 16'hF00F, 0);
        go(0);
        for (int k = 1; k <= 4; k++) go(k);
        async_rst();
        step(0, 16'h0000, 1);
        go(5);
        go(0);
        go(1);
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 20) step(0, 16'($urandom), 0);
            else if (r < 70) go(m_lock ? m_exp : 0);
            else if (r < 88) go(int'($urandom_range(0, 8)));
            else step(1, 16'($urandom), 0);
        end
        step(0, 16'h0000, 0);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            $display("FAIL drain: %0d expected items left, required 0", q.size());
            $fatal(1);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
